// File: rtl/kalman_filter_1d.sv
// Scalar fixed-point Kalman filter: one 16-bit sample in, updated estimate out
// with a stretched done strobe for a slower downstream serial clock.
module kalman_filter_1d #(
    parameter logic [15:0] Q_NOISE     = 16'd4,
    parameter logic [15:0] R_NOISE     = 16'd256,
    parameter logic [15:0] P_INIT      = 16'd1024,
    parameter int          DONE_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sample,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic [15:0] filtered_data,
    output logic        filter_done,
    output logic        overrun
);

    localparam int CW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
    localparam logic [CW-1:0] DONE_LOAD = CW'(DONE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PREDICT,
        DIVIDE,
        UPDATE,
        DONE
    } state_t;

    state_t         state;
    logic [15:0]    x;
    logic [15:0]    p;
    logic [15:0]    pp;
    logic [15:0]    z;
    logic           init_done;
    logic [16:0]    d;
    logic [16:0]    rem;
    logic [15:0]    dl;
    logic [15:0]    q;
    logic [3:0]     div_cnt;
    logic [CW-1:0]  done_cnt;

    logic [16:0]        p_sum;
    logic [15:0]        pp_next;
    logic [17:0]        trial;
    logic               fits;
    logic [14:0]        k;
    logic signed [16:0] e;
    logic signed [32:0] ke;
    logic signed [18:0] delta;
    logic signed [18:0] x_sum;
    logic [15:0]        x_new;
    logic [30:0]        kp;
    logic [15:0]        p_new;

    assign sample_ready = (state == IDLE);

    assign p_sum   = {1'b0, p} + {1'b0, Q_NOISE};
    assign pp_next = p_sum[16] ? 16'hFFFF : p_sum[15:0];

    // Restoring divider: remainder stays below D, so 17 bits hold it
    assign trial = {rem, dl[15]};
    assign fits  = (trial >= {1'b0, d});

    always_comb begin
        k = 15'd0;
        if (d != 17'd0)
            k = q[15] ? 15'h7FFF : q[14:0];
    end

    assign e     = $signed({1'b0, z}) - $signed({1'b0, x});
    assign ke    = $signed({1'b0, k}) * e;
    assign delta = 19'(ke >>> 15);
    assign x_sum = $signed({3'b000, x}) + delta;

    always_comb begin
        x_new = x_sum[15:0];
        if (x_sum < 0)
            x_new = 16'h0000;
        else if (x_sum > 19'sd65535)
            x_new = 16'hFFFF;
    end

    assign kp    = k * pp;
    assign p_new = pp - 16'(kp >> 15);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            x             <= '0;
            p             <= '0;
            pp            <= '0;
            z             <= '0;
            init_done     <= 1'b0;
            d             <= '0;
            rem           <= '0;
            dl            <= '0;
            q             <= '0;
            div_cnt       <= '0;
            done_cnt      <= '0;
            filtered_data <= '0;
            filter_done   <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            if (sample_valid && state != IDLE)
                overrun <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (sample_valid) begin
                        z <= sample;
                        if (!init_done) begin
                            x             <= sample;
                            p             <= P_INIT;
                            init_done     <= 1'b1;
                            filtered_data <= sample;
                            filter_done   <= 1'b1;
                            done_cnt      <= DONE_LOAD;
                            state         <= DONE;
                        end else begin
                            state <= PREDICT;
                        end
                    end
                end
                PREDICT: begin
                    pp      <= pp_next;
                    d       <= {1'b0, pp_next} + {1'b0, R_NOISE};
                    rem     <= {2'b00, pp_next[15:1]};
                    dl      <= {pp_next[0], 15'd0};
                    q       <= '0;
                    div_cnt <= 4'd15;
                    state   <= DIVIDE;
                end
                DIVIDE: begin
                    if (fits) begin
                        rem <= 17'(trial - {1'b0, d});
                        q   <= {q[14:0], 1'b1};
                    end else begin
                        rem <= trial[16:0];
                        q   <= {q[14:0], 1'b0};
                    end
                    dl <= {dl[14:0], 1'b0};
                    if (div_cnt == 4'd0)
                        state <= UPDATE;
                    else
                        div_cnt <= div_cnt - 4'd1;
                end
                UPDATE: begin
                    x             <= x_new;
                    p             <= p_new;
                    filtered_data <= x_new;
                    filter_done   <= 1'b1;
                    done_cnt      <= DONE_LOAD;
                    state         <= DONE;
                end
                DONE: begin
                    if (done_cnt == '0) begin
                        filter_done <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        done_cnt <= done_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kalman_filter_1d.sv
// Directed bench for kalman_filter_1d: hand-derived vectors plus a small
// covariance model for the constant-input run.
module tb_kalman_filter_1d;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sample = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [15:0] filtered_data;
    logic        filter_done;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    kalman_filter_1d dut (
        .clk(clk),
        .rst(rst),
        .sample(sample),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .filtered_data(filtered_data),
        .filter_done(filter_done),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Leaves the bench in cycle 1 relative to the acceptance edge
    task automatic send(input logic [15:0] v);
        sample       = v;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic run_first(input logic [15:0] v);
        send(v);
        chk("first_data", filtered_data, v);
        chk("first_done", filter_done, 1'b1);
        chk("first_ready_low", sample_ready, 1'b0);
        chk("first_p", dut.p, 16'd1024);
        repeat (7) tick();
        chk("first_done_c8", filter_done, 1'b1);
        tick();
        chk("first_ready_c9", sample_ready, 1'b1);
        chk("first_done_c9", filter_done, 1'b0);
    endtask

    task automatic run_normal(input logic [15:0] v, input logic [15:0] exp_x,
                              input logic [15:0] exp_p);
        send(v);
        chk("norm_ready_c1", sample_ready, 1'b0);
        repeat (17) tick();
        chk("norm_done_c18", filter_done, 1'b0);
        tick();
        chk("norm_data_c19", filtered_data, exp_x);
        chk("norm_done_c19", filter_done, 1'b1);
        chk("norm_p", dut.p, exp_p);
        repeat (7) tick();
        chk("norm_done_c26", filter_done, 1'b1);
        chk("norm_data_c26", filtered_data, exp_x);
        tick();
        chk("norm_ready_c27", sample_ready, 1'b1);
        chk("norm_done_c27", filter_done, 1'b0);
    endtask

    function automatic int next_p(input int pin);
        longint ppm;
        longint dm;
        longint km;
        ppm = longint'(pin) + 4;
        if (ppm > 65535) ppm = 65535;
        dm = ppm + 256;
        km = (dm == 0) ? 0 : (ppm * 32768) / dm;
        if (km > 32767) km = 32767;
        return int'(ppm - ((km * ppm) >> 15));
    endfunction

    int pm;

    initial begin
        tick();
        chk("rst_data", filtered_data, 16'h0000);
        chk("rst_done", filter_done, 1'b0);
        chk("rst_ready", sample_ready, 1'b1);
        chk("rst_overrun", overrun, 1'b0);
        rst = 1'b0;
        tick();

        run_first(16'h1234);
        run_normal(16'h2234, 16'h1F03, 16'd205);

        do_reset();
        run_first(16'h1234);
        run_normal(16'h0234, 16'h0564, 16'd205);

        // Overrun during DIVIDE must not disturb the in-flight sample
        do_reset();
        run_first(16'h1234);
        send(16'h2234);
        repeat (3) tick();
        sample       = 16'hFFFF;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("ovr_set", overrun, 1'b1);
        repeat (13) tick();
        chk("ovr_done_c18", filter_done, 1'b0);
        tick();
        chk("ovr_data_c19", filtered_data, 16'h1F03);
        chk("ovr_p", dut.p, 16'd205);
        repeat (8) tick();
        chk("ovr_ready_c27", sample_ready, 1'b1);
        chk("ovr_sticky", overrun, 1'b1);
        repeat (3) tick();
        chk("ovr_data_idle", filtered_data, 16'h1F03);

        // Asynchronous reset in the middle of DIVIDE
        send(16'h2234);
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_data", filtered_data, 16'h0000);
        chk("arst_done", filter_done, 1'b0);
        chk("arst_ready", sample_ready, 1'b1);
        chk("arst_overrun", overrun, 1'b0);
        #1;
        rst = 1'b0;
        tick();
        run_first(16'h00AA);

        do_reset();
        run_first(16'h8000);
        pm = 1024;
        for (int i = 0; i < 9; i++) begin
            pm = next_p(pm);
            run_normal(16'h8000, 16'h8000, 16'(pm));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
